// File: rtl/bcrypt_pkg.sv
// Shared types and constants for the bcrypt host byte-stream interface.
package bcrypt_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SALT,
        KEY,
        COST,
        START,
        WAIT,
        CT_SEND,
        CT_SHIFT
    } state_t;

    localparam logic [7:0]  HDR_BYTE   = 8'hB5;
    localparam int unsigned SALT_WORDS = 4;
    localparam int unsigned KEY_WORDS  = 18;
    localparam int unsigned CT_WORDS   = 6;

    // True when idx is the final word of the section being loaded.
    function automatic logic is_last_word(input state_t st, input logic [4:0] idx);
        case (st)
            SALT:    return idx == 5'(SALT_WORDS - 1);
            KEY:     return idx == 5'(KEY_WORDS - 1);
            COST:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Section that follows a completed load section.
    function automatic state_t next_section(input state_t st);
        case (st)
            SALT:    return KEY;
            KEY:     return COST;
            COST:    return START;
            default: return IDLE;
        endcase
    endfunction

endpackage

// File: rtl/bcrypt_host_if_if.sv
// Byte-stream, core-load and core-control signals of the bcrypt host interface.
interface bcrypt_host_if_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] load_word;
    logic        shift_salt_l;
    logic        shift_salt_r;
    logic        shift_key;
    logic        shift_cost;
    logic        core_start;
    logic        core_done;
    logic [31:0] ct_word;
    logic        sel_ct;
    logic        shift_ct;
    logic        busy;
    logic        hdr_err;

    modport slave (
        input  rx_data, rx_valid, tx_ready, core_done, ct_word,
        output rx_ready, tx_data, tx_valid, load_word, shift_salt_l, shift_salt_r,
               shift_key, shift_cost, core_start, sel_ct, shift_ct, busy, hdr_err
    );

    modport master (
        output rx_data, rx_valid, tx_ready, core_done, ct_word,
        input  rx_ready, tx_data, tx_valid, load_word, shift_salt_l, shift_salt_r,
               shift_key, shift_cost, core_start, sel_ct, shift_ct, busy, hdr_err
    );
endinterface

// File: rtl/bcrypt_tx_serializer.sv
// 32-bit word to MSB-first byte stream with valid/ready handshake.
module bcrypt_tx_serializer (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_i,
    input  logic [31:0] word_i,
    input  logic        tx_ready_i,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    output logic        last_o
);
    logic [31:0] sh_q, sh_d;
    logic [2:0]  left_q, left_d;

    assign tx_valid_o = (left_q != 3'd0);
    assign tx_data_o  = sh_q[31:24];
    assign last_o     = tx_valid_o && tx_ready_i && (left_q == 3'd1);

    // Load a fresh word or shift out one byte per accepted handshake.
    always_comb begin
        sh_d   = sh_q;
        left_d = left_q;
        if (load_i) begin
            sh_d   = word_i;
            left_d = 3'd4;
        end else if (tx_valid_o && tx_ready_i) begin
            sh_d   = {sh_q[23:0], 8'h00};
            left_d = left_q - 3'd1;
        end
    end

    // Shift register and down-counter of bytes still to send.
    always_ff @(posedge clk) begin
        if (reset) begin
            sh_q   <= '0;
            left_q <= '0;
        end else begin
            sh_q   <= sh_d;
            left_q <= left_d;
        end
    end
endmodule

// File: rtl/bcrypt_host_if.sv
// Frame parser, word assembler and ciphertext return sequencer for the bcrypt core.
//
// state    | meaning
// IDLE     | waiting for header byte; other bytes flagged via hdr_err
// SALT     | assembling 4 salt words
// KEY      | assembling 18 key words
// COST     | assembling the cost word
// START    | one-cycle core_start pulse
// WAIT     | waiting for core_done
// CT_SEND  | loading/sending one ciphertext word
// CT_SHIFT | one-cycle shift_ct pulse between L/R pairs
module bcrypt_host_if
    import bcrypt_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    bcrypt_host_if_if.slave bus
);
    state_t      state_q, state_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [4:0]  word_cnt_q, word_cnt_d;
    logic [31:0] asm_q, asm_d;
    logic        strobe_q, strobe_d;
    logic        hdr_err_q, hdr_err_d;
    logic [2:0]  ct_idx_q, ct_idx_d;
    logic        load_pend_q, load_pend_d;

    logic rx_ready, salt_l, salt_r, key_stb, cost_stb, core_start, shift_ct;
    logic ser_load, ser_last;

    bcrypt_tx_serializer u_ser (
        .clk        (clk),
        .reset      (reset),
        .load_i     (ser_load),
        .word_i     (bus.ct_word),
        .tx_ready_i (bus.tx_ready),
        .tx_data_o  (bus.tx_data),
        .tx_valid_o (bus.tx_valid),
        .last_o     (ser_last)
    );

    assign bus.rx_ready     = rx_ready;
    assign bus.load_word    = asm_q;
    assign bus.shift_salt_l = salt_l;
    assign bus.shift_salt_r = salt_r;
    assign bus.shift_key    = key_stb;
    assign bus.shift_cost   = cost_stb;
    assign bus.core_start   = core_start;
    assign bus.sel_ct       = ct_idx_q[0];
    assign bus.shift_ct     = shift_ct;
    assign bus.busy         = (state_q != IDLE);
    assign bus.hdr_err      = hdr_err_q;

    // Next-state, counters and all FSM-driven outputs.
    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        word_cnt_d  = word_cnt_q;
        asm_d       = asm_q;
        strobe_d    = strobe_q;
        hdr_err_d   = 1'b0;
        ct_idx_d    = ct_idx_q;
        load_pend_d = load_pend_q;
        rx_ready    = 1'b0;
        salt_l      = 1'b0;
        salt_r      = 1'b0;
        key_stb     = 1'b0;
        cost_stb    = 1'b0;
        core_start  = 1'b0;
        shift_ct    = 1'b0;
        ser_load    = 1'b0;
        case (state_q)
            IDLE: begin
                rx_ready = 1'b1;
                if (bus.rx_valid) begin
                    if (bus.rx_data == HDR_BYTE) begin
                        state_d    = SALT;
                        byte_cnt_d = '0;
                        word_cnt_d = '0;
                        asm_d      = '0;
                    end else begin
                        hdr_err_d = 1'b1;
                    end
                end
            end
            SALT, KEY, COST: begin
                if (strobe_q) begin
                    // Strobe cycle: word is stable on load_word, input stalled.
                    strobe_d   = 1'b0;
                    salt_l     = (state_q == SALT) && !word_cnt_q[0];
                    salt_r     = (state_q == SALT) && word_cnt_q[0];
                    key_stb    = (state_q == KEY);
                    cost_stb   = (state_q == COST);
                    word_cnt_d = word_cnt_q + 5'd1;
                    if (is_last_word(state_q, word_cnt_q)) begin
                        word_cnt_d = '0;
                        state_d    = next_section(state_q);
                    end
                end else begin
                    rx_ready = 1'b1;
                    if (bus.rx_valid) begin
                        asm_d      = {asm_q[23:0], bus.rx_data};
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) strobe_d = 1'b1;
                    end
                end
            end
            START: begin
                core_start = 1'b1;
                state_d    = WAIT;
            end
            WAIT: begin
                if (bus.core_done) begin
                    state_d     = CT_SEND;
                    ct_idx_d    = '0;
                    load_pend_d = 1'b1;
                end
            end
            CT_SEND: begin
                // Capture happens one cycle after entry so sel_ct already matches the index.
                if (load_pend_q) begin
                    ser_load    = 1'b1;
                    load_pend_d = 1'b0;
                end else if (ser_last) begin
                    if (!ct_idx_q[0]) begin
                        ct_idx_d    = ct_idx_q + 3'd1;
                        load_pend_d = 1'b1;
                    end else if (ct_idx_q == 3'(CT_WORDS - 1)) begin
                        ct_idx_d = '0;
                        state_d  = IDLE;
                    end else begin
                        state_d = CT_SHIFT;
                    end
                end
            end
            CT_SHIFT: begin
                shift_ct    = 1'b1;
                ct_idx_d    = ct_idx_q + 3'd1;
                load_pend_d = 1'b1;
                state_d     = CT_SEND;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            byte_cnt_q  <= '0;
            word_cnt_q  <= '0;
            asm_q       <= '0;
            strobe_q    <= 1'b0;
            hdr_err_q   <= 1'b0;
            ct_idx_q    <= '0;
            load_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            word_cnt_q  <= word_cnt_d;
            asm_q       <= asm_d;
            strobe_q    <= strobe_d;
            hdr_err_q   <= hdr_err_d;
            ct_idx_q    <= ct_idx_d;
            load_pend_q <= load_pend_d;
        end
    end
endmodule

// File: tb/tb_bcrypt_host_if.sv
// Self-checking bench for bcrypt_host_if: header table, frame scoreboard, ciphertext return.
module tb_bcrypt_host_if;
    import bcrypt_pkg::*;

    localparam int K_SL = 0, K_SR = 1, K_KEY = 2, K_COST = 3, K_START = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bcrypt_host_if_if bus ();

    bcrypt_host_if dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int          kind;
        logic [31:0] word;
    } ev_t;

    typedef struct {
        logic [7:0] b;
        logic       exp_err;
        logic       exp_busy;
        logic       exp_rdy;
    } hv_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    ev_t         exp_q[$];
    logic [7:0]  exp_tx[$];
    int          tx_seen = 0;
    int          shift_seen = 0;
    logic [31:0] salt [4];
    logic [31:0] ct_l [3];
    logic [31:0] ct_r [3];
    string       ct_str = "OrpheanBeholderScryDoubt";
    int          ct_pos;

    // Ciphertext chain model: restarts on core_start, advances on shift_ct.
    always @(posedge clk) begin
        if (reset || bus.core_start) ct_pos <= 0;
        else if (bus.shift_ct)       ct_pos <= ct_pos + 1;
    end

    always_comb begin
        int p;
        p = (ct_pos > 2) ? 2 : ct_pos;
        bus.ct_word = bus.sel_ct ? ct_r[p] : ct_l[p];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard side: strobe/start events and transmitted bytes.
    always @(negedge clk) begin
        int  nh;
        int  k;
        ev_t e;
        if (!reset) begin
            nh = int'(bus.shift_salt_l) + int'(bus.shift_salt_r) + int'(bus.shift_key)
               + int'(bus.shift_cost) + int'(bus.core_start) + int'(bus.shift_ct);
            if (nh > 0) chk("pulse_exclusive", (nh > 1) ? 32'd1 : 32'd0, 32'd0);
            if (bus.shift_ct) shift_seen++;
            k = -1;
            if (bus.shift_salt_l)      k = K_SL;
            else if (bus.shift_salt_r) k = K_SR;
            else if (bus.shift_key)    k = K_KEY;
            else if (bus.shift_cost)   k = K_COST;
            else if (bus.core_start)   k = K_START;
            if (k >= 0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_event", 32'(k), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("event_kind", 32'(k), 32'(e.kind));
                    if (k != K_START) chk("load_word", bus.load_word, e.word);
                end
            end
            if (bus.tx_valid && bus.tx_ready) begin
                tx_seen++;
                if (exp_tx.size() == 0) chk("unexpected_tx", {24'h0, bus.tx_data}, 32'hFFFF_FFFF);
                else chk("tx_byte", {24'h0, bus.tx_data}, {24'h0, exp_tx.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        bus.rx_valid = 1'b0;
        bus.core_done = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        exp_q.delete();
        exp_tx.delete();
    endtask

    // Drive one byte after 'gap' idle cycles; returns just after the accepting edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        logic acc;
        int   n;
        bus.rx_valid = 1'b0;
        repeat (gap) tick();
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        n   = 0;
        acc = 1'b0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = bus.rx_ready;
            tick();
            n++;
        end
        bus.rx_valid = 1'b0;
        if (!acc) chk("rx_accept_timeout", 32'd0, 32'd1);
    endtask

    function automatic logic [31:0] key_word(input int k);
        return {8'(k), 8'hA5, 8'(k * 3 + 1), 8'h5A};
    endfunction

    task automatic send_word(input int kind, input logic [31:0] w, input int gapmax);
        exp_q.push_back('{kind, w});
        for (int i = 0; i < 4; i++) send_byte(w[31 - 8*i -: 8], int'($urandom_range(gapmax, 0)));
    endtask

    task automatic send_frame(input int gapmax);
        send_byte(HDR_BYTE, int'($urandom_range(gapmax, 0)));
        for (int i = 0; i < 4; i++) send_word((i % 2 == 1) ? K_SR : K_SL, salt[i], gapmax);
        for (int k = 0; k < 18; k++) send_word(K_KEY, key_word(k), gapmax);
        exp_q.push_back('{K_COST, 32'h0000_000C});
        exp_q.push_back('{K_START, 32'h0});
        for (int i = 0; i < 4; i++) send_byte(8'(i == 3 ? 8'h0C : 8'h00), int'($urandom_range(gapmax, 0)));
    endtask

    task automatic wait_idle(input int maxc);
        int n = 0;
        while (bus.busy && n < maxc) begin
            tick();
            n++;
        end
        @(negedge clk);
        chk("busy_end", {31'h0, bus.busy}, 32'd0);
        tick();
    endtask

    // Wait for the core_start event, hold in WAIT 10 cycles, then collect the ciphertext.
    task automatic run_ct(input bit stall);
        int n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        chk("events_drained", 32'(exp_q.size()), 32'd0);
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h11;
        @(negedge clk);
        chk("wait_rx_ready", {31'h0, bus.rx_ready}, 32'd0);
        chk("wait_busy", {31'h0, bus.busy}, 32'd1);
        tick();
        bus.rx_valid = 1'b0;
        repeat (9) tick();
        shift_seen = 0;
        tx_seen    = 0;
        for (int i = 0; i < 24; i++) exp_tx.push_back(ct_str[i]);
        bus.tx_ready  = 1'b1;
        bus.core_done = 1'b1;
        tick();
        bus.core_done = 1'b0;
        if (stall) begin
            n = 0;
            while (tx_seen < 2 && n < 50) begin
                tick();
                n++;
            end
            chk("stall_reach", 32'(tx_seen), 32'd2);
            bus.tx_ready = 1'b0;
            for (int i = 0; i < 7; i++) begin
                @(negedge clk);
                chk("stall_valid", {31'h0, bus.tx_valid}, 32'd1);
                chk("stall_data", {24'h0, bus.tx_data}, {24'h0, exp_tx[0]});
            end
            tick();
            bus.tx_ready = 1'b1;
        end
        wait_idle(300);
        chk("tx_queue_empty", 32'(exp_tx.size()), 32'd0);
        chk("tx_count", 32'(tx_seen), 32'd24);
        chk("shift_ct_count", 32'(shift_seen), 32'd2);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        hv_t hv [4];
        salt = '{32'h0011_2233, 32'h4455_6677, 32'h8899_AABB, 32'hCCDD_EEFF};
        ct_l = '{32'h4F72_7068, 32'h6568_6F6C, 32'h6372_7944};
        ct_r = '{32'h6561_6E42, 32'h6465_7253, 32'h6F75_6274};
        hv[0] = '{8'h00, 1'b1, 1'b0, 1'b1};
        hv[1] = '{8'hFF, 1'b1, 1'b0, 1'b1};
        hv[2] = '{8'hB4, 1'b1, 1'b0, 1'b1};
        hv[3] = '{8'hB5, 1'b0, 1'b1, 1'b1};
        bus.rx_data   = 8'h00;
        bus.rx_valid  = 1'b0;
        bus.tx_ready  = 1'b0;
        bus.core_done = 1'b0;
        reset = 1'b1;
        tick();
        do_reset();

        // Reset state
        @(negedge clk);
        chk("rst_busy", {31'h0, bus.busy}, 32'd0);
        chk("rst_rx_ready", {31'h0, bus.rx_ready}, 32'd1);
        chk("rst_tx_valid", {31'h0, bus.tx_valid}, 32'd0);
        chk("rst_hdr_err", {31'h0, bus.hdr_err}, 32'd0);
        chk("rst_load_word", bus.load_word, 32'd0);
        chk("rst_sel_ct", {31'h0, bus.sel_ct}, 32'd0);
        tick();

        // core_done while idle must be ignored
        bus.tx_ready  = 1'b1;
        bus.core_done = 1'b1;
        tick();
        bus.core_done = 1'b0;
        repeat (10) tick();
        @(negedge clk);
        chk("stray_done_busy", {31'h0, bus.busy}, 32'd0);
        chk("stray_done_tx", {31'h0, bus.tx_valid}, 32'd0);
        tick();

        // Header byte table
        for (int i = 0; i < 4; i++) begin
            do_reset();
            send_byte(hv[i].b, 0);
            @(negedge clk);
            chk("hdr_err", {31'h0, bus.hdr_err}, {31'h0, hv[i].exp_err});
            chk("hdr_busy", {31'h0, bus.busy}, {31'h0, hv[i].exp_busy});
            chk("hdr_rx_ready", {31'h0, bus.rx_ready}, {31'h0, hv[i].exp_rdy});
            @(negedge clk);
            chk("hdr_err_single", {31'h0, bus.hdr_err}, 32'd0);
            tick();
        end

        // Bad header then a gapless valid frame with ciphertext return
        do_reset();
        send_byte(8'h00, 0);
        @(negedge clk);
        chk("bad_hdr_pulse", {31'h0, bus.hdr_err}, 32'd1);
        tick();
        send_frame(0);
        run_ct(1'b0);

        // Random gaps between bytes, stalled transmitter mid-word
        send_frame(5);
        run_ct(1'b1);

        // Reset after 50 key bytes, then a full frame
        send_byte(HDR_BYTE, 0);
        for (int i = 0; i < 4; i++) send_word((i % 2 == 1) ? K_SR : K_SL, salt[i], 0);
        for (int k = 0; k < 12; k++) send_word(K_KEY, key_word(k), 0);
        send_byte(8'h77, 0);
        send_byte(8'h88, 0);
        chk("pre_reset_events", 32'(exp_q.size()), 32'd0);
        do_reset();
        @(negedge clk);
        chk("mid_reset_busy", {31'h0, bus.busy}, 32'd0);
        chk("mid_reset_rx_ready", {31'h0, bus.rx_ready}, 32'd1);
        tick();
        repeat (20) tick();
        send_frame(2);
        run_ct(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
